// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
// The state encoding is visible on the debug port, so the values are fixed.
package pll_sup_pkg;

    localparam int unsigned DefRstCycles   = 16;
    localparam int unsigned DefLockStable  = 1024;
    localparam int unsigned DefLockTimeout = 65536;
    localparam int unsigned DefMaxRetries  = 3;

    typedef enum logic [2:0] {
        StResetPll = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } state_e;

    // Width of the shared cycle counter: one bit above what the largest count needs.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $unsigned($clog2(m)) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and reset-side signals of the lock supervisor.
// master = the supervisor; slave = the PLL / reset consumers.
interface pll_lock_supervisor_if;

    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       fail;
    logic [7:0] relock_count;
    logic [2:0] state_o;

    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst_n,
        output fail,
        output relock_count,
        output state_o
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst_n,
        input  fail,
        input  relock_count,
        input  state_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with asynchronous active-low reset.
// Also used by each domain that consumes sys_rst_n.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Reset/lock supervisor for the system PLL: pulses pll_rst, waits for a steady lock,
// then releases sys_rst_n; repeated lock timeouts latch a failure.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = DefRstCycles,
    parameter int unsigned LOCK_STABLE  = DefLockStable,
    parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
    parameter int unsigned MAX_RETRIES  = DefMaxRetries
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.master sup
);

    localparam int unsigned CntW   = cnt_width(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT,
                                               MAX_RETRIES);
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    localparam logic [CntW-1:0]   RstLast     = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0]   StableLast  = CntW'(LOCK_STABLE - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [RetryW-1:0] RetryLimit  = RetryW'(MAX_RETRIES);

    logic locked_s;

    sync_2ff u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (sup.pll_locked),
        .q_o    (locked_s)
    );

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RetryW-1:0] retries_q, retries_d;
    logic [7:0]        relock_q, relock_d;
    logic              pll_rst_q, pll_rst_d;
    logic              sys_rst_n_q, sys_rst_n_d;
    logic              fail_q, fail_d;

    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        relock_d  = relock_q;
        // RUN and FAIL are untimed; holding the counter there keeps it from wrapping.
        cnt_d     = (state_q == StRun || state_q == StFail) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            StResetPll: begin
                if (cnt_q == RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                // A lock seen on the timeout cycle takes priority over the retry.
                if (locked_s) begin
                    state_d = StStable;
                end else if (cnt_q == TimeoutLast) begin
                    retries_d = retries_q + 1'b1;
                    state_d   = (retries_d == RetryLimit) ? StFail : StResetPll;
                end
            end
            StStable: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!locked_s) begin
                    state_d = StResetPll;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StFail;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
        if (state_d == StRun && state_q != StRun) retries_d = '0;

        // Outputs are decoded from the next state so they register with the state.
        pll_rst_d   = (state_d == StResetPll);
        sys_rst_n_d = (state_d == StRun);
        fail_d      = (state_d == StFail);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StResetPll;
            cnt_q       <= '0;
            retries_q   <= '0;
            relock_q    <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            relock_q    <= relock_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            fail_q      <= fail_d;
        end
    end

    assign sup.pll_rst      = pll_rst_q;
    assign sup.sys_rst_n    = sys_rst_n_q;
    assign sup.fail         = fail_q;
    assign sup.relock_count = relock_q;
    assign sup.state_o      = state_q;

    // Output invariants: the PLL is never in reset while the system is released,
    // and the failure state holds both resets in their safe levels.
    a_rst_exclusive: assert property (@(posedge refclk) disable iff (!rst_n)
        !(pll_rst_q && sys_rst_n_q));
    a_fail_safe: assert property (@(posedge refclk) disable iff (!rst_n)
        fail_q |-> (!pll_rst_q && !sys_rst_n_q));
    a_fail_sticky: assert property (@(posedge refclk) disable iff (!rst_n)
        fail_q |=> fail_q);
    a_retries_bound: assert property (@(posedge refclk) disable iff (!rst_n)
        retries_q <= RetryLimit);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: defaults, short timeout, and relock saturation.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    logic refclk;
    logic rst_na, rst_nb, rst_nc;

    pll_lock_supervisor_if ifa ();
    pll_lock_supervisor_if ifb ();
    pll_lock_supervisor_if ifc ();

    pll_lock_supervisor dut_a (
        .refclk (refclk),
        .rst_n  (rst_na),
        .sup    (ifa)
    );

    pll_lock_supervisor #(.LOCK_TIMEOUT(64)) dut_b (
        .refclk (refclk),
        .rst_n  (rst_nb),
        .sup    (ifb)
    );

    pll_lock_supervisor #(.RST_CYCLES(1), .LOCK_STABLE(2)) dut_c (
        .refclk (refclk),
        .rst_n  (rst_nc),
        .sup    (ifc)
    );

    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_total  = 0;
    int  n_passed = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_q.push_back('{tag, exp});
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        n_total = n_total + 1;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) n_passed = n_passed + 1;
            else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic wait_c(input logic [2:0] st, input bit want_eq, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if ((ifc.state_o == st) == want_eq) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, required finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int falls;
        logic prev;

        rst_na = 1'b0;
        rst_nb = 1'b0;
        rst_nc = 1'b0;
        ifa.pll_locked = 1'b0;
        ifb.pll_locked = 1'b0;
        ifc.pll_locked = 1'b0;
        step(3);

        // Reset state
        push("a_rst_pll_rst", 1); push("a_rst_sys_rst_n", 0); push("a_rst_fail", 0);
        push("a_rst_relock", 0);  push("a_rst_state", 32'(StResetPll));
        check(32'(ifa.pll_rst)); check(32'(ifa.sys_rst_n)); check(32'(ifa.fail));
        check(32'(ifa.relock_count)); check(32'(ifa.state_o));

        // Normal lock: release at cycle 0, lock before edge 40, release at edge 1066
        rst_na = 1'b1;
        push("a_pll_rst_e15", 1);
        step(15); check(32'(ifa.pll_rst));
        push("a_pll_rst_e16", 0); push("a_state_e16", 32'(StWaitLock));
        step(1); check(32'(ifa.pll_rst)); check(32'(ifa.state_o));
        step(23);
        ifa.pll_locked = 1'b1;
        push("a_state_e41", 32'(StWaitLock));
        step(2); check(32'(ifa.state_o));
        push("a_state_e42", 32'(StStable));
        step(1); check(32'(ifa.state_o));
        push("a_sys_e1065", 0);
        step(1023); check(32'(ifa.sys_rst_n));
        push("a_sys_e1066", 1); push("a_state_e1066", 32'(StRun));
        step(1); check(32'(ifa.sys_rst_n)); check(32'(ifa.state_o));

        // Loss in RUN
        ifa.pll_locked = 1'b0;
        push("a_loss_sys_k1", 1);
        step(2); check(32'(ifa.sys_rst_n));
        push("a_loss_sys_k2", 0); push("a_loss_pll_rst_k2", 1);
        push("a_loss_relock", 1); push("a_loss_state_k2", 32'(StResetPll));
        step(1);
        check(32'(ifa.sys_rst_n)); check(32'(ifa.pll_rst));
        check(32'(ifa.relock_count)); check(32'(ifa.state_o));
        ifa.pll_locked = 1'b1;
        push("a_loss_pulse_15", 1);
        step(15); check(32'(ifa.pll_rst));
        push("a_loss_pulse_16", 0);
        step(1); check(32'(ifa.pll_rst));
        push("a_relock_sys_early", 0);
        step(1024); check(32'(ifa.sys_rst_n));
        push("a_relock_sys", 1); push("a_relock_count", 1);
        step(1); check(32'(ifa.sys_rst_n)); check(32'(ifa.relock_count));

        // Asynchronous reset during RUN
        rst_na = 1'b0;
        #1;
        push("a_arst_run_pll_rst", 1); push("a_arst_run_sys", 0); push("a_arst_run_fail", 0);
        push("a_arst_run_relock", 0);  push("a_arst_run_state", 32'(StResetPll));
        check(32'(ifa.pll_rst)); check(32'(ifa.sys_rst_n)); check(32'(ifa.fail));
        check(32'(ifa.relock_count)); check(32'(ifa.state_o));

        // Lock glitch 500 cycles into STABLE
        rst_na = 1'b1;
        push("g_state_e16", 32'(StWaitLock));
        step(16); check(32'(ifa.state_o));
        push("g_state_e17", 32'(StStable));
        step(1); check(32'(ifa.state_o));
        step(500);
        ifa.pll_locked = 1'b0;
        step(1);
        ifa.pll_locked = 1'b1;
        push("g_state_e519", 32'(StStable));
        step(1); check(32'(ifa.state_o));
        push("g_state_e520", 32'(StWaitLock)); push("g_retries_e520", 0);
        step(1); check(32'(ifa.state_o)); check(32'(dut_a.retries_q));
        push("g_state_e521", 32'(StStable));
        step(1); check(32'(ifa.state_o));
        push("g_sys_e1544", 0); push("g_retries_e1544", 0);
        step(1023); check(32'(ifa.sys_rst_n)); check(32'(dut_a.retries_q));
        push("g_sys_e1545", 1);
        step(1); check(32'(ifa.sys_rst_n));

        // Asynchronous reset during WAIT_LOCK
        rst_na = 1'b0;
        #1;
        ifa.pll_locked = 1'b0;
        rst_na = 1'b1;
        push("w_state", 32'(StWaitLock)); push("w_pll_rst", 0);
        step(20); check(32'(ifa.state_o)); check(32'(ifa.pll_rst));
        rst_na = 1'b0;
        #1;
        push("a_arst_wait_pll_rst", 1); push("a_arst_wait_sys", 0);
        push("a_arst_wait_relock", 0);  push("a_arst_wait_state", 32'(StResetPll));
        check(32'(ifa.pll_rst)); check(32'(ifa.sys_rst_n));
        check(32'(ifa.relock_count)); check(32'(ifa.state_o));

        // Timeout with LOCK_TIMEOUT=64: pulses at 0, 80, 160; FAIL from edge 240
        rst_nb = 1'b1;
        falls  = 0;
        prev   = 1'b1;
        for (int e = 1; e <= 300; e++) begin
            if (e == 260) ifb.pll_locked = 1'b1;
            push($sformatf("t_pll_rst_e%0d", e), 32'((e < 240) && (e % 80 < 16)));
            push($sformatf("t_fail_e%0d", e), 32'(e >= 240));
            step(1);
            check(32'(ifb.pll_rst));
            check(32'(ifb.fail));
            if (prev && !ifb.pll_rst) falls++;
            prev = ifb.pll_rst;
        end
        push("t_pulse_count", 3); push("t_sys_rst_n", 0); push("t_state", 32'(StFail));
        check(32'(falls)); check(32'(ifb.sys_rst_n)); check(32'(ifb.state_o));

        // Saturation: 300 lock losses with RST_CYCLES=1, LOCK_STABLE=2
        rst_nc = 1'b1;
        ifc.pll_locked = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            push("s_reach_run", 1);
            wait_c(3'(StRun), 1'b1, ok);
            check(32'(ok));
            ifc.pll_locked = 1'b0;
            push("s_leave_run", 1);
            wait_c(3'(StRun), 1'b0, ok);
            check(32'(ok));
            ifc.pll_locked = 1'b1;
            if (i == 1 || i == 254 || i == 255) begin
                push($sformatf("s_relock_%0d", i), i);
                check(32'(ifc.relock_count));
            end
        end
        push("s_relock_sat", 255);
        check(32'(ifc.relock_count));

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
